contador_crescente_sinc: RTL and testbench

//   Synchronous, modulo-N up counter built from JK flip-flop cells with look-ahead toggle logic.
//   It counts upward from 0 and is the counterpart to our ripple down-counter, which presets to all-ones.

---
 rtl/contador_pkg.sv | 17 +
 rtl/jk_ff_sync.sv | 28 ++
 rtl/contador_crescente_sinc.sv | 139 +++++++++++++
 tb/tb_contador_crescente_sinc.sv | 200 ++++++++++++++++++++
 4 files changed

// File: rtl/contador_pkg.sv
// Shared encodings for the synchronous JK-based up counter: FSM state codes and run modes.
package contador_pkg;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  localparam logic MODE_CONT    = 1'b0;
  localparam logic MODE_ONESHOT = 1'b1;

  typedef enum logic [1:0] {
    S_IDLE = ST_IDLE,
    S_RUN  = ST_RUN,
    S_DONE = ST_DONE
  } state_e;

endpackage

// File: rtl/jk_ff_sync.sv
// Single JK flip-flop cell with synchronous active-high reset to 0.
// Function table {j,k}: 00 hold, 01 clear, 10 set, 11 toggle.
module jk_ff_sync (
  input  logic clk_i,
  input  logic rst_i,
  input  logic j_i,
  input  logic k_i,
  output logic q_o
);

  logic q_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      q_q <= 1'b0;
    end else begin
      case ({j_i, k_i})
        2'b00:   q_q <= q_q;
        2'b01:   q_q <= 1'b0;
        2'b10:   q_q <= 1'b1;
        default: q_q <= ~q_q;
      endcase
    end
  end

  assign q_o = q_q;

endmodule

// File: rtl/contador_crescente_sinc.sv
// Synchronous modulo-MODULO up counter built from JK cells with look-ahead toggle logic,
// plus IDLE/RUN/DONE run control, one-shot mode, synchronous load and tc/wrap/load_err flags.
module contador_crescente_sinc #(
  parameter int WIDTH  = 5,
  parameter int MODULO = 20
) (
  input  logic             clk_principal,
  input  logic             reset_principal,
  input  logic             start,
  input  logic             stop,
  input  logic             mode,
  input  logic             en,
  input  logic             clear,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  output logic [WIDTH-1:0] saida,
  output logic             busy,
  output logic             done,
  output logic             tc,
  output logic             wrap,
  output logic             load_err,
  output logic [1:0]       state_dbg
);

  import contador_pkg::*;

  localparam logic [WIDTH-1:0] TC_VAL  = WIDTH'(MODULO - 1);
  localparam logic [WIDTH:0]   MOD_EXT = (WIDTH + 1)'(MODULO);

  state_e           state_q;
  logic             mode_q;
  logic             wrap_q;
  logic             load_err_q;
  logic [WIDTH-1:0] cnt_q;

  logic             at_tc;
  logic             load_oor;
  logic             adv;
  logic             force_en;
  logic [WIDTH-1:0] force_val;
  logic [WIDTH-1:0] tog;
  logic [WIDTH-1:0] j;
  logic [WIDTH-1:0] k;
  logic             ones_below;

  assign at_tc    = (cnt_q == TC_VAL);
  assign load_oor = ({1'b0, load_val} >= MOD_EXT);

  // Plain increment only; wrap, load, clear and restart go through the forced path.
  assign adv = (state_q == S_RUN) & en & ~at_tc & ~clear & ~load & ~stop;

  always_comb begin
    tog        = '0;
    ones_below = adv;
    for (int i = 0; i < WIDTH; i++) begin
      tog[i]     = ones_below;
      ones_below = ones_below & cnt_q[i];
    end
  end

  always_comb begin
    force_en  = 1'b0;
    force_val = '0;
    if (clear) begin
      force_en = 1'b1;
    end else if (load) begin
      force_en  = 1'b1;
      force_val = load_oor ? TC_VAL : load_val;
    end else if ((state_q == S_RUN) && !stop && en && at_tc && (mode_q == MODE_CONT)) begin
      force_en = 1'b1;
    end else if ((state_q == S_DONE) && start) begin
      force_en = 1'b1;
    end
  end

  assign j = force_en ? force_val  : tog;
  assign k = force_en ? ~force_val : tog;

  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    jk_ff_sync u_jk (
      .clk_i (clk_principal),
      .rst_i (reset_principal),
      .j_i   (j[i]),
      .k_i   (k[i]),
      .q_o   (cnt_q[i])
    );
  end

  always_ff @(posedge clk_principal) begin
    if (reset_principal) begin
      state_q    <= S_IDLE;
      mode_q     <= MODE_CONT;
      wrap_q     <= 1'b0;
      load_err_q <= 1'b0;
    end else begin
      wrap_q     <= 1'b0;
      load_err_q <= 1'b0;
      if (clear) begin
        state_q <= S_IDLE;
      end else if (load) begin
        load_err_q <= load_oor;
        if (state_q != S_RUN) state_q <= S_IDLE;
      end else begin
        case (state_q)
          S_IDLE: begin
            if (!stop && start) begin
              state_q <= S_RUN;
              mode_q  <= mode;
            end
          end
          S_RUN: begin
            if (stop) begin
              state_q <= S_IDLE;
            end else if (en && at_tc) begin
              if (mode_q == MODE_ONESHOT) state_q <= S_DONE;
              else                        wrap_q  <= 1'b1;
            end
          end
          S_DONE: begin
            if (start) begin
              state_q <= S_RUN;
              mode_q  <= mode;
            end
          end
          default: state_q <= S_IDLE;
        endcase
      end
    end
  end

  assign saida     = cnt_q;
  assign busy      = (state_q == S_RUN);
  assign done      = (state_q == S_DONE);
  assign tc        = busy & en & at_tc;
  assign wrap      = wrap_q;
  assign load_err  = load_err_q;
  assign state_dbg = state_q;

endmodule

// File: tb/tb_contador_crescente_sinc.sv
// Directed bench for contador_crescente_sinc: a MODULO=20 instance and a MODULO=32 instance
// share all inputs; inputs are driven and outputs sampled on the falling clock edge.
module tb_contador_crescente_sinc;

  localparam int W = 5;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic         start = 1'b0, stop = 1'b0, mode = 1'b0, en = 1'b0;
  logic         clear = 1'b0, load = 1'b0;
  logic [W-1:0] load_val = '0;

  logic [W-1:0] saida, saida2;
  logic         busy, done, tc, wrap, load_err;
  logic         busy2, done2, tc2, wrap2, load_err2;
  logic [1:0]   st_dbg, st_dbg2;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  contador_crescente_sinc #(.WIDTH(W), .MODULO(20)) dut (
    .clk_principal(clk), .reset_principal(rst), .start(start), .stop(stop), .mode(mode),
    .en(en), .clear(clear), .load(load), .load_val(load_val), .saida(saida), .busy(busy),
    .done(done), .tc(tc), .wrap(wrap), .load_err(load_err), .state_dbg(st_dbg)
  );

  contador_crescente_sinc #(.WIDTH(W), .MODULO(32)) dut32 (
    .clk_principal(clk), .reset_principal(rst), .start(start), .stop(stop), .mode(mode),
    .en(en), .clear(clear), .load(load), .load_val(load_val), .saida(saida2), .busy(busy2),
    .done(done2), .tc(tc2), .wrap(wrap2), .load_err(load_err2), .state_dbg(st_dbg2)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick(input int n = 1);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      @(negedge clk);
    end
  endtask

  task automatic idle_inputs();
    start = 1'b0; stop = 1'b0; mode = 1'b0; en = 1'b0;
    clear = 1'b0; load = 1'b0; load_val = '0;
  endtask

  task automatic do_clear();
    clear = 1'b1; tick(); clear = 1'b0;
  endtask

  task automatic do_start(input logic m);
    start = 1'b1; mode = m; en = 1'b1; tick(); start = 1'b0;
  endtask

  initial begin
    @(negedge clk);
    // 1: reset, continuous count 0..19 then wrap
    rst = 1'b1; tick(); rst = 1'b0;
    check("rst_saida", saida, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_wrap", wrap, 0);
    check("rst_load_err", load_err, 0);
    check("rst_state", st_dbg, 0);
    do_start(1'b0);
    check("t1_busy", busy, 1);
    for (int c = 0; c < 20; c++) begin
      check($sformatf("t1_saida_%0d", c), saida, c);
      check($sformatf("t1_tc_%0d", c), tc, (c == 19));
      check($sformatf("t1_wrap_%0d", c), wrap, 0);
      tick();
    end
    check("t1_wrapped_saida", saida, 0);
    check("t1_wrap_pulse", wrap, 1);
    tick();
    check("t1_wrap_gone", wrap, 0);
    check("t1_after_wrap", saida, 1);

    // 2: one-shot reaches 19, parks in DONE, restart from 0
    do_clear();
    check("t2_clear_saida", saida, 0);
    check("t2_clear_busy", busy, 0);
    do_start(1'b1);
    tick(19);
    check("t2_at19", saida, 19);
    check("t2_at19_busy", busy, 1);
    check("t2_at19_tc", tc, 1);
    tick();
    check("t2_done", done, 1);
    check("t2_busy0", busy, 0);
    check("t2_state_done", st_dbg, 2);
    check("t2_no_wrap", wrap, 0);
    for (int c = 0; c < 10; c++) begin
      stop = (c == 3);
      tick();
      check($sformatf("t2_hold_%0d", c), saida, 19);
      check($sformatf("t2_done_%0d", c), done, 1);
    end
    stop = 1'b0;
    do_start(1'b0);
    check("t2_restart_saida", saida, 0);
    check("t2_restart_busy", busy, 1);
    check("t2_restart_done", done, 0);

    // 3: en gating, stop, resume, stop beats start
    do_clear();
    do_start(1'b0);
    tick(7);
    check("t3_at7", saida, 7);
    en = 1'b0;
    for (int c = 0; c < 5; c++) begin
      check($sformatf("t3_tc_gated_%0d", c), tc, 0);
      tick();
      check($sformatf("t3_hold_%0d", c), saida, 7);
    end
    stop = 1'b1; tick(); stop = 1'b0;
    check("t3_stop_busy", busy, 0);
    check("t3_stop_saida", saida, 7);
    do_start(1'b0);
    check("t3_resume_busy", busy, 1);
    check("t3_resume_saida", saida, 7);
    tick();
    check("t3_8", saida, 8);
    tick();
    check("t3_9", saida, 9);
    stop = 1'b1; tick();
    start = 1'b1; tick(); start = 1'b0; stop = 1'b0;
    check("t3_stop_start_busy", busy, 0);
    check("t3_stop_start_saida", saida, 9);

    // 4: clamped load in IDLE, in-range load mid-RUN
    load = 1'b1; load_val = 5'd25; tick(); load = 1'b0;
    check("t4_clamp_saida", saida, 19);
    check("t4_clamp_err", load_err, 1);
    check("t4_clamp_busy", busy, 0);
    check("t4_32_noclamp", saida2, 25);
    check("t4_32_noerr", load_err2, 0);
    tick();
    check("t4_err_pulse_end", load_err, 0);
    do_clear();
    do_start(1'b0);
    tick(2);
    check("t4_at2", saida, 2);
    load = 1'b1; load_val = 5'd5; tick(); load = 1'b0;
    check("t4_load5", saida, 5);
    check("t4_load5_busy", busy, 1);
    check("t4_load5_err", load_err, 0);
    tick();
    check("t4_6", saida, 6);

    // 5: clear wins over load/start; synchronous reset mid-count
    clear = 1'b1; load = 1'b1; load_val = 5'd3; start = 1'b1; tick();
    idle_inputs();
    check("t5_prio_saida", saida, 0);
    check("t5_prio_busy", busy, 0);
    check("t5_prio_err", load_err, 0);
    do_start(1'b0);
    tick(12);
    check("t5_at12", saida, 12);
    rst = 1'b1;
    #1;
    check("t5_sync_saida", saida, 12);
    check("t5_sync_busy", busy, 1);
    tick();
    rst = 1'b0;
    check("t5_rst_saida", saida, 0);
    check("t5_rst_busy", busy, 0);
    check("t5_rst_done", done, 0);
    check("t5_rst_wrap", wrap, 0);
    check("t5_rst_err", load_err, 0);

    // 6: MODULO == 2**WIDTH natural wrap 31 -> 0
    idle_inputs();
    do_clear();
    do_start(1'b0);
    for (int c = 0; c < 32; c++) begin
      check($sformatf("t6_saida_%0d", c), saida2, c);
      check($sformatf("t6_tc_%0d", c), tc2, (c == 31));
      tick();
    end
    check("t6_wrapped", saida2, 0);
    check("t6_wrap_pulse", wrap2, 1);
    check("t6_busy", busy2, 1);
    tick();
    check("t6_wrap_end", wrap2, 0);
    check("t6_after", saida2, 1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
